// File: rtl/arp_rx.sv
// arp_rx: receive-side ARP parser. Captures the fixed-position ARP fields
// from 64-bit payload beats, validates the frame against the local IP/MAC,
// and pulses a target-valid (and, for requests, a reply) strobe.
module arp_rx #(
  parameter logic [31:0] P_SRC_IP_ADDR  = {8'd192, 8'd168, 8'd100, 8'd99},
  parameter logic [47:0] P_SRC_MAC_ADDR = 48'h01_02_03_04_05_06
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dymanic_src_ip,
  input  logic        i_src_ip_valid,
  input  logic [47:0] i_dymanic_src_mac,
  input  logic        i_src_mac_valid,
  input  logic [63:0] s_axis_arp_data,
  input  logic [79:0] s_axis_arp_user,
  input  logic [7:0]  s_axis_arp_keep,
  input  logic        s_axis_arp_last,
  input  logic        s_axis_arp_valid,
  output logic [47:0] o_recv_target_mac,
  output logic [31:0] o_recv_target_ip,
  output logic        o_recv_target_valid,
  output logic        o_arp_reply,
  output logic [15:0] o_recv_op,
  output logic [15:0] o_drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] local_ip;
  logic [47:0] local_mac;
  logic [2:0]  beat_cnt;
  logic [15:0] eth_type, htype, ptype, op;
  logic [7:0]  hlen, plen;
  logic [47:0] sha;
  logic [31:0] spa, tpa;

  logic first_beat, next_beat, eval, frame_ok;

  // keep and the length/source-MAC sideband carry nothing the parser needs
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_arp_keep, s_axis_arp_user[79:16]};

  // All acceptance rules applied to the fields captured for the current frame
  assign frame_ok = (beat_cnt >= 3'd4) &&
                    (eth_type == 16'h0806) &&
                    (htype == 16'h0001) && (ptype == 16'h0800) &&
                    (hlen == 8'd6) && (plen == 8'd4) &&
                    ((op == 16'd1) || (op == 16'd2)) &&
                    (tpa == local_ip) &&
                    (sha != local_mac);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a beat seen in IDLE or EVAL always starts a new frame
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (s_axis_arp_valid) state_nxt = s_axis_arp_last ? S_EVAL : S_RECV;
      end
      S_RECV: begin
        if (s_axis_arp_valid && s_axis_arp_last) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (s_axis_arp_valid) state_nxt = s_axis_arp_last ? S_EVAL : S_RECV;
        else                  state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state control decode for the capture and evaluation datapath
  always_comb begin
    first_beat = 1'b0;
    next_beat  = 1'b0;
    eval       = 1'b0;
    case (state)
      S_IDLE: first_beat = s_axis_arp_valid;
      S_RECV: next_beat  = s_axis_arp_valid;
      S_EVAL: begin
        eval       = 1'b1;
        first_beat = s_axis_arp_valid;
      end
      default: ;
    endcase
  end

  // Local address registers; a same-cycle evaluation still sees the old value
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      local_ip  <= P_SRC_IP_ADDR;
      local_mac <= P_SRC_MAC_ADDR;
    end else begin
      if (i_src_ip_valid)  local_ip  <= i_dymanic_src_ip;
      if (i_src_mac_valid) local_mac <= i_dymanic_src_mac;
    end
  end

  // Beat counter (saturating at 7) and fixed-position field capture
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      beat_cnt <= 3'd0;
      eth_type <= 16'd0;
      htype    <= 16'd0;
      ptype    <= 16'd0;
      hlen     <= 8'd0;
      plen     <= 8'd0;
      op       <= 16'd0;
      sha      <= 48'd0;
      spa      <= 32'd0;
      tpa      <= 32'd0;
    end else if (first_beat) begin
      beat_cnt <= 3'd1;
      {htype, ptype, hlen, plen, op} <= s_axis_arp_data;
      eth_type <= s_axis_arp_user[15:0];
    end else if (next_beat) begin
      if (beat_cnt != 3'd7) beat_cnt <= beat_cnt + 3'd1;
      case (beat_cnt)
        3'd1:    {sha, spa[31:16]} <= s_axis_arp_data;
        3'd2:    spa[15:0] <= s_axis_arp_data[63:48];
        3'd3:    tpa <= s_axis_arp_data[63:32];
        default: ;
      endcase
    end else if (eval) begin
      beat_cnt <= 3'd0;
    end
  end

  // Result outputs: strobes for one cycle after EVAL, data held until next accept
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_recv_target_mac   <= 48'd0;
      o_recv_target_ip    <= 32'd0;
      o_recv_target_valid <= 1'b0;
      o_arp_reply         <= 1'b0;
      o_recv_op           <= 16'd0;
      o_drop_cnt          <= 16'd0;
    end else begin
      o_recv_target_valid <= eval && frame_ok;
      o_arp_reply         <= eval && frame_ok && (op == 16'd1);
      if (eval) begin
        if (frame_ok) begin
          o_recv_target_mac <= sha;
          o_recv_target_ip  <= spa;
          o_recv_op         <= op;
        end else begin
          o_drop_cnt <= o_drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule
